// File: rtl/isp_pkg.sv
// Shared ISP definitions: picture geometry, DRAM layout, beat tags and
// reader FSM states. Also imported by the ISP core.
package isp_pkg;

    localparam logic [31:0] DRAM_BASE      = 32'h0001_0000;
    localparam int          PIC_BYTES      = 3072;
    localparam int          BEATS_PER_PIC  = 192;
    localparam int          BEATS_PER_CHAN = 64;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    // Sideband that travels with every beat through the skid buffer.
    typedef struct packed {
        chan_e      chan;
        logic [4:0] row;
        logic       half;
        logic       last;
    } pix_tag_t;

    // Byte offset of picture pic: pic*3072 built from two shifts, no multiplier.
    function automatic logic [31:0] pic_offset(input logic [3:0] pic);
        logic [31:0] p;
        p = {28'd0, pic};
        return (p << 11) + (p << 10);
    endfunction

endpackage

// File: rtl/isp_skid_fifo.sv
// Two-entry FIFO between the AXI R channel and the ISP core. Push and pop may
// happen in the same cycle, including when full.
module isp_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/isp_dram_reader.sv
// AXI4 read master: fetches one 32x32 RGB picture as a single 192-beat INCR
// burst and streams tagged beats to the ISP core through a skid buffer.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RD_IDLE | waiting for a picture request, req_ready high
//   RD_ADDR | presenting the burst address until arready
//   RD_DATA | accepting R beats, draining until the last beat is popped
module isp_dram_reader #(
    parameter int          DATA_W    = 128,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = isp_pkg::DRAM_BASE,
    parameter int          PIC_BYTES = isp_pkg::PIC_BYTES,
    parameter int          BEATS     = isp_pkg::BEATS_PER_PIC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_pic_no,
    output logic [3:0]        arid_m_inf,
    output logic [ADDR_W-1:0] araddr_m_inf,
    output logic [7:0]        arlen_m_inf,
    output logic [2:0]        arsize_m_inf,
    output logic [1:0]        arburst_m_inf,
    output logic              arvalid_m_inf,
    input  logic              arready_m_inf,
    input  logic [3:0]        rid_m_inf,
    input  logic [DATA_W-1:0] rdata_m_inf,
    input  logic [1:0]        rresp_m_inf,
    input  logic              rlast_m_inf,
    input  logic              rvalid_m_inf,
    output logic              rready_m_inf,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic [1:0]        pix_chan,
    output logic [4:0]        pix_row,
    output logic              pix_half,
    output logic              pix_last,
    output logic              err
);

    import isp_pkg::*;

    localparam int         FW        = DATA_W + $bits(pix_tag_t);
    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    rd_state_e         state, state_nx;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        rcnt;
    logic              rd_done;
    logic              rready_q;
    logic              err_q;
    logic              push, pop, push_last;
    logic [1:0]        fifo_count, fifo_count_nx;
    pix_tag_t          push_tag, head_tag;
    logic [FW-1:0]     head_word;
    logic              unused_rid;

    assign unused_rid = ^rid_m_inf;

    assign req_ready     = (state == RD_IDLE);
    assign arid_m_inf    = 4'd0;
    assign araddr_m_inf  = araddr_q;
    assign arlen_m_inf   = 8'(PIC_BYTES / (DATA_W / 8) - 1);
    assign arsize_m_inf  = 3'b100;
    assign arburst_m_inf = 2'b01;
    assign arvalid_m_inf = (state == RD_ADDR);
    assign rready_m_inf  = rready_q;
    assign err           = err_q;

    assign push      = rvalid_m_inf && rready_q;
    assign pop       = pix_valid && pix_ready;
    // An early rlast or the 192nd beat both close the picture.
    assign push_last = (rcnt == LAST_BEAT) || rlast_m_inf;

    // rcnt/64 gives the channel; within a channel two beats make one row.
    assign push_tag = '{chan: chan_e'(rcnt[7:6]), row: rcnt[5:1],
                        half: rcnt[0], last: push_last};

    assign fifo_count_nx = fifo_count + 2'(push) - 2'(pop);

    isp_skid_fifo #(.W(FW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({rdata_m_inf, push_tag}),
        .pop   (pop),
        .dout  (head_word),
        .count (fifo_count)
    );

    assign {pix_data, head_tag} = head_word;
    assign pix_valid = (fifo_count != 2'd0);
    assign pix_chan  = head_tag.chan;
    assign pix_row   = head_tag.row;
    assign pix_half  = head_tag.half;
    assign pix_last  = head_tag.last;

    // Next-state: request, address handshake, then pop of the tagged last beat.
    always_comb begin
        state_nx = state;
        case (state)
            RD_IDLE: if (req_valid)         state_nx = RD_ADDR;
            RD_ADDR: if (arready_m_inf)     state_nx = RD_DATA;
            RD_DATA: if (pop && pix_last)   state_nx = RD_IDLE;
            default:                        state_nx = RD_IDLE;
        endcase
    end

    // State register, burst address, beat counter, R-side throttle and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RD_IDLE;
            araddr_q <= '0;
            rcnt     <= 8'd0;
            rd_done  <= 1'b0;
            rready_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == RD_IDLE) && req_valid) begin
                araddr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(pic_offset(req_pic_no));
                err_q    <= 1'b0;
                rcnt     <= 8'd0;
                rd_done  <= 1'b0;
            end
            if (push) begin
                rcnt <= rcnt + 8'd1;
                if (push_last) begin
                    rd_done <= 1'b1;
                end
                if ((rresp_m_inf != 2'b00) || (rlast_m_inf != (rcnt == LAST_BEAT))) begin
                    err_q <= 1'b1;
                end
            end
            // Throttle from the occupancy the FIFO will have next cycle so a
            // registered rready can never overrun the two entries.
            rready_q <= (state_nx == RD_DATA) && !(rd_done || (push && push_last))
                        && (fifo_count_nx < 2'd2);
        end
    end

endmodule
